// File: rtl/mem_burst_ctrl.sv
// mem_burst_ctrl: burst master streaming sequential words between a write/read port and a single-port memory
module mem_burst_ctrl #(
  parameter int width = 8,
  parameter int depth = 16,
  parameter int addr = $clog2(depth)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [addr-1:0]  cmd_addr,
  input  logic [addr:0]    cmd_len,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [width-1:0] wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [width-1:0] rd_data,
  output logic             valid,
  output logic             rw_en,
  output logic [addr-1:0]  addr_i,
  output logic [width-1:0] w_data,
  input  logic             ready,
  input  logic [width-1:0] r_data,
  output logic             busy,
  output logic             done
);
  localparam logic [addr:0] full = (addr+1)'(depth);
  localparam logic [addr:0] one = (addr+1)'(1);
  localparam logic [addr-1:0] last = addr'(depth - 1);
  typedef enum logic [2:0] {IDLE, WR, RD, RD_WAIT, FIN} state_t;
  state_t state, state_n;
  logic [addr-1:0] cur_addr, addr_next;
  logic [addr:0] remaining, len_clamped;
  logic beat;
  assign len_clamped = cmd_len > full ? full : cmd_len;
  assign addr_next = cur_addr == last ? '0 : cur_addr + 1'b1;
  assign beat = valid && ready;
  // State register
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  // Burst position: latched on command acceptance, advanced on each memory handshake
  always_ff @(posedge clk)
    if (rst) begin
      cur_addr <= '0;
      remaining <= '0;
    end else if (state == IDLE && cmd_valid) begin
      cur_addr <= cmd_addr;
      remaining <= len_clamped;
    end else if (beat) begin
      cur_addr <= addr_next;
      remaining <= remaining - 1'b1;
    end
  // Read output register: loads memory data one cycle after the read handshake, drains on rd_ready
  always_ff @(posedge clk)
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data <= '0;
    end else if (state == RD_WAIT) begin
      rd_valid <= 1'b1;
      rd_data <= r_data;
    end else if (rd_ready) rd_valid <= 1'b0;
  // Next-state logic
  always_comb begin
    state_n = state;
    case (state)
      IDLE: if (cmd_valid) state_n = len_clamped == '0 ? FIN : cmd_write ? WR : RD;
      WR: if (beat && remaining == one) state_n = FIN;
      RD: if (beat) state_n = RD_WAIT;
      RD_WAIT: state_n = remaining == '0 ? FIN : RD;
      FIN: if (!rd_valid) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // Outputs; a read is only issued when the output register will be free at the next edge
  always_comb begin
    busy = state != IDLE;
    cmd_ready = state == IDLE;
    rw_en = state == WR;
    valid = state == WR ? wr_valid : state == RD ? (!rd_valid || rd_ready) : 1'b0;
    addr_i = cur_addr;
    w_data = state == WR ? wr_data : '0;
    wr_ready = state == WR && ready;
    done = state == FIN && !rd_valid;
  end
endmodule

// File: tb/tb_mem_burst_ctrl.sv
// tb_mem_burst_ctrl: randomized scoreboard bench for mem_burst_ctrl with a behavioural memory
module tb_mem_burst_ctrl;
  localparam int W = 8, D = 16, A = 4;
  logic clk = 0, rst = 1;
  logic cmd_valid = 0, cmd_ready, cmd_write = 0;
  logic [A-1:0] cmd_addr = '0;
  logic [A:0] cmd_len = '0;
  logic wr_valid = 0, wr_ready;
  logic [W-1:0] wr_data = '0;
  logic rd_valid, rd_ready = 0;
  logic [W-1:0] rd_data;
  logic valid, rw_en, ready = 0;
  logic [A-1:0] addr_i;
  logic [W-1:0] w_data, r_data = '0;
  logic busy, done;
  int checks = 0, failures = 0;

  mem_burst_ctrl #(.width(W), .depth(D)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .valid(valid), .rw_en(rw_en), .addr_i(addr_i), .w_data(w_data),
    .ready(ready), .r_data(r_data), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [W-1:0] mem_arr [D];
  logic [W-1:0] ref_mem [D];
  logic [W-1:0] wr_src [$];
  logic [W-1:0] exp_rd [$];
  logic [12:0] exp_mem [$];
  int exp_done = 0, cyc = 0, last_evt = 0, last_rd = 0, rd_beats = 0;
  int ready_pct = 100, rd_pct = 100, wr_pct = 100;
  bit tput_chk = 0, rd_pend = 0, w_hold = 0, p_wstall = 0, p_rstall = 0;
  logic [W-1:0] pend_data, p_wdata, p_rdata;
  logic [A-1:0] p_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got an event, expected none at %0t", name, $time);
  endtask

  // Memory responder, port drivers and monitor: inputs change on the falling edge,
  // everything is sampled 1ns before the rising edge it will act on.
  initial begin
    for (int i = 0; i < D; i++) begin
      mem_arr[i] = W'($urandom);
      ref_mem[i] = mem_arr[i];
    end
    forever begin
      @(negedge clk);
      ready = $urandom_range(0, 99) < ready_pct;
      rd_ready = $urandom_range(0, 99) < rd_pct;
      r_data = rd_pend ? pend_data : W'($urandom);
      rd_pend = 0;
      if (!w_hold) begin
        wr_valid = wr_src.size() > 0 && $urandom_range(0, 99) < wr_pct;
        wr_data = wr_src.size() > 0 ? wr_src[0] : W'($urandom);
      end
      #4;
      cyc++;
      if (rst) begin
        p_wstall = 0;
        p_rstall = 0;
        w_hold = 0;
      end else begin
        check("cmd_ready_vs_busy", 32'(cmd_ready), 32'(!busy));
        if (!busy) check("idle_quiet", 32'({valid, wr_ready, done}), 0);
        if (valid && rw_en) check("wr_ready_passthru", 32'(wr_ready), 32'(ready));
        if (rd_valid && !rd_ready) check("rd_issue_blocked", 32'(valid), 0);
        if (p_wstall) begin
          check("stall_hold_valid", 32'(valid), 1);
          check("stall_hold_addr", 32'(addr_i), 32'(p_addr));
          check("stall_hold_data", 32'(w_data), 32'(p_wdata));
        end
        if (p_rstall) begin
          check("rd_hold_valid", 32'(rd_valid), 1);
          check("rd_hold_data", 32'(rd_data), 32'(p_rdata));
        end
        if (cmd_valid && cmd_ready) begin
          last_evt = cyc;
          rd_beats = 0;
        end
        if (valid && ready) begin
          last_evt = cyc;
          if (exp_mem.size() == 0) fail("mem_unexpected");
          else check("mem_beat", 32'({rw_en, addr_i, rw_en ? w_data : 8'h00}), 32'(exp_mem.pop_front()));
          if (rw_en) mem_arr[addr_i] = w_data;
          else begin
            rd_pend = 1;
            pend_data = mem_arr[addr_i];
          end
        end
        if (wr_valid && wr_ready && wr_src.size() > 0) void'(wr_src.pop_front());
        w_hold = wr_valid && !wr_ready;
        if (rd_valid && rd_ready) begin
          last_evt = cyc;
          if (tput_chk && rd_beats > 0) check("rd_rate", cyc - last_rd, 2);
          rd_beats++;
          last_rd = cyc;
          if (exp_rd.size() == 0) fail("rd_unexpected");
          else check("rd_beat", 32'(rd_data), 32'(exp_rd.pop_front()));
        end
        if (done) begin
          check("done_timing", cyc, last_evt + 1);
          check("done_busy", 32'(busy), 1);
          if (exp_done == 0) fail("done_unexpected");
          else exp_done--;
        end
        p_wstall = valid && rw_en && !ready;
        p_addr = addr_i;
        p_wdata = w_data;
        p_rstall = rd_valid && !rd_ready;
        p_rdata = rd_data;
      end
    end
  end

  // Reference model: a burst touches min(len, D) consecutive addresses modulo D
  task automatic expect_cmd(input bit w, input int a, input int l, input int base);
    int n;
    n = l > D ? D : l;
    for (int i = 0; i < n; i++) begin
      int ad;
      logic [W-1:0] d;
      ad = (a + i) % D;
      d = base >= 0 ? W'(base + i) : W'($urandom);
      if (w) begin
        wr_src.push_back(d);
        exp_mem.push_back({1'b1, A'(ad), d});
        ref_mem[ad] = d;
      end else begin
        exp_mem.push_back({1'b0, A'(ad), 8'h00});
        exp_rd.push_back(ref_mem[ad]);
      end
    end
    exp_done++;
  endtask

  task automatic flush();
    exp_mem.delete();
    exp_rd.delete();
    wr_src.delete();
    exp_done = 0;
  endtask

  task automatic issue(input bit w, input int a, input int l);
    @(negedge clk);
    cmd_valid = 1;
    cmd_write = w;
    cmd_addr = A'(a);
    cmd_len = (A+1)'(l);
    @(negedge clk);
    cmd_valid = 0;
  endtask

  task automatic wait_done();
    for (int t = 0; t < 3000 && exp_done != 0; t++) begin
      @(negedge clk);
      cmd_valid = exp_done != 0 && $urandom_range(0, 3) == 0;
      cmd_write = 1'($urandom);
      cmd_addr = A'($urandom);
      cmd_len = (A+1)'($urandom);
    end
    cmd_valid = 0;
    if (exp_done != 0) begin
      fail("burst_timeout");
      rst = 1;
      flush();
      @(negedge clk);
      rst = 0;
    end
    @(negedge clk);
    check("queues_drained", exp_mem.size() + exp_rd.size() + wr_src.size(), 0);
    check("idle_after_done", 32'(busy), 0);
  endtask

  task automatic run_cmd(input bit w, input int a, input int l, input int base);
    expect_cmd(w, a, l, base);
    issue(w, a, l);
    wait_done();
  endtask

  task automatic reset_check(input string tag);
    check({tag, "_ctl"}, 32'({valid, rw_en, wr_ready, rd_valid, busy, done, cmd_ready}), 32'b0000001);
    check({tag, "_addr"}, 32'(addr_i), 0);
    check({tag, "_wdata"}, 32'(w_data), 0);
    check({tag, "_rdata"}, 32'(rd_data), 0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    reset_check("reset");
    rst = 0;
    // Fill then drain the whole memory at full rate
    run_cmd(1, 0, 16, 0);
    tput_chk = 1;
    run_cmd(0, 0, 16, -1);
    tput_chk = 0;
    // Wrap around the top of the address space
    run_cmd(1, 14, 4, 'hA0);
    check("wrap_mem14", 32'(mem_arr[14]), 'hA0);
    check("wrap_mem1", 32'(mem_arr[1]), 'hA3);
    run_cmd(0, 14, 4, -1);
    // Read-port backpressure right after the first beat appears
    expect_cmd(0, 2, 3, -1);
    rd_pct = 0;
    issue(0, 2, 3);
    for (int t = 0; t < 100 && !rd_valid; t++) @(negedge clk);
    check("bp_first_valid", 32'(rd_valid), 1);
    repeat (5) @(negedge clk);
    #1 rd_pct = 100;
    wait_done();
    // Memory stall in the middle of a write burst
    expect_cmd(1, 5, 6, -1);
    issue(1, 5, 6);
    for (int t = 0; t < 100 && wr_src.size() > 4; t++) @(negedge clk);
    #1 ready_pct = 0;
    repeat (3) @(negedge clk);
    #1 ready_pct = 100;
    wait_done();
    run_cmd(0, 5, 6, -1);
    // Zero-length and over-length commands
    run_cmd(1, 7, 0, -1);
    run_cmd(0, 9, 0, -1);
    run_cmd(1, 3, 20, -1);
    run_cmd(0, 3, 31, -1);
    // Randomized traffic with random handshake pressure
    repeat (30) begin
      ready_pct = $urandom_range(40, 100);
      rd_pct = $urandom_range(40, 100);
      wr_pct = $urandom_range(40, 100);
      run_cmd(1'($urandom), $urandom_range(0, D - 1), $urandom_range(0, 20), -1);
    end
    ready_pct = 100;
    rd_pct = 100;
    wr_pct = 100;
    // Reset in the middle of a read burst
    expect_cmd(0, 3, 10, -1);
    issue(0, 3, 10);
    for (int t = 0; t < 200 && rd_beats < 3; t++) @(negedge clk);
    check("abort_progress", 32'(rd_beats >= 3), 1);
    rst = 1;
    flush();
    @(negedge clk);
    reset_check("abort");
    rst = 0;
    repeat (20) @(negedge clk);
    run_cmd(0, 0, 16, -1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
